// File: rtl/spring_if.sv
// Spring controller signal bundle: frame/key/pause/restart controls in,
// launch speed, plunger displacement and status out.
interface spring_if;
  logic               startOfFrame;
  logic               keyIsPressed;
  logic               pause;
  logic               reset_level;
  logic signed [31:0] springSpeedY;
  logic        [7:0]  compression;
  logic               launchPulse;
  logic               springBusy;

  modport master (
    output startOfFrame, keyIsPressed, pause, reset_level,
    input  springSpeedY, compression, launchPulse, springBusy
  );

  modport slave (
    input  startOfFrame, keyIsPressed, pause, reset_level,
    output springSpeedY, compression, launchPulse, springBusy
  );
endinterface

// File: rtl/spring_controller.sv
// Plunger/launcher controller. Key hold time (in frames) becomes spring
// compression; releasing the key fires a launch speed proportional to the
// compression while the plunger retracts, followed by a cooldown in which
// the key is ignored. All state advances only on unpaused frame ticks.
// Legal parameters keep 255 * SPEED_FACTOR inside a 32-bit signed value.
module spring_controller #(
  parameter int MAX_COMPRESSION = 32,
  parameter int CHARGE_STEP     = 1,
  parameter int RETRACT_STEP    = 8,
  parameter int SPEED_FACTOR    = 8,
  parameter int MIN_COMPRESSION = 4,
  parameter int COOLDOWN_FRAMES = 30,
  parameter int DATA_W          = 32
) (
  input  logic     clk,
  input  logic     resetN,
  spring_if.slave  spring
);

  typedef enum logic [1:0] {IDLE, CHARGING, RELEASE, COOLDOWN} state_t;

  state_t                    state, state_next;
  logic        [7:0]         comp, comp_next;
  logic signed [DATA_W-1:0]  speed, speed_next;
  logic signed [DATA_W-1:0]  launch_speed, launch_speed_next;
  logic        [15:0]        cool_cnt, cool_cnt_next;
  logic                      pulse, pulse_next;
  logic                      busy, busy_next;
  logic                      frame_tick;

  // Compression after one charging frame, held at the maximum.
  function automatic logic [7:0] charge_sat(input logic [7:0] c);
    int sum;
    sum = int'(c) + CHARGE_STEP;
    if (sum > MAX_COMPRESSION) sum = MAX_COMPRESSION;
    return 8'(sum);
  endfunction

  // Compression after one retract frame, floored at zero.
  function automatic logic [7:0] retract_sat(input logic [7:0] c);
    int diff;
    diff = int'(c) - RETRACT_STEP;
    if (diff < 0) diff = 0;
    return 8'(diff);
  endfunction

  // Upward (negative) launch speed proportional to compression.
  function automatic logic signed [DATA_W-1:0] launch_velocity(input logic [7:0] c);
    logic signed [DATA_W-1:0] mag;
    mag = $signed({{(DATA_W-8){1'b0}}, c}) * $signed(DATA_W'(SPEED_FACTOR));
    return -mag;
  endfunction

  assign frame_tick = spring.startOfFrame && !spring.pause;

  // State and datapath registers; both restart sources clear everything.
  always_ff @(posedge clk) begin
    if (resetN || spring.reset_level) begin
      state        <= IDLE;
      comp         <= 8'd0;
      speed        <= '0;
      launch_speed <= '0;
      cool_cnt     <= 16'd0;
      pulse        <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_next;
      comp         <= comp_next;
      speed        <= speed_next;
      launch_speed <= launch_speed_next;
      cool_cnt     <= cool_cnt_next;
      pulse        <= pulse_next;
      busy         <= busy_next;
    end
  end

  // Next-state and next-output decode; everything holds off-frame except
  // the launch strobe, which always drops after one clock.
  always_comb begin
    state_next        = state;
    comp_next         = comp;
    speed_next        = speed;
    launch_speed_next = launch_speed;
    cool_cnt_next     = cool_cnt;
    pulse_next        = 1'b0;
    if (frame_tick) begin
      case (state)
        IDLE: begin
          if (spring.keyIsPressed) begin
            state_next = CHARGING;
            comp_next  = charge_sat(8'd0);
          end
        end
        CHARGING: begin
          if (spring.keyIsPressed) begin
            comp_next = charge_sat(comp);
          end else if (int'(comp) >= MIN_COMPRESSION) begin
            launch_speed_next = launch_velocity(comp);
            speed_next        = launch_velocity(comp);
            state_next        = RELEASE;
            pulse_next        = 1'b1;
          end else begin
            state_next = IDLE;
            comp_next  = 8'd0;
          end
        end
        RELEASE: begin
          comp_next  = retract_sat(comp);
          speed_next = launch_speed;
          if (retract_sat(comp) == 8'd0) begin
            state_next    = COOLDOWN;
            speed_next    = '0;
            cool_cnt_next = 16'(COOLDOWN_FRAMES);
          end
        end
        COOLDOWN: begin
          comp_next  = 8'd0;
          speed_next = '0;
          if (cool_cnt <= 16'd1) begin
            cool_cnt_next = 16'd0;
            state_next    = IDLE;
          end else begin
            cool_cnt_next = cool_cnt - 16'd1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
    busy_next = (state_next != IDLE);
  end

  assign spring.springSpeedY = speed;
  assign spring.compression  = comp;
  assign spring.launchPulse  = pulse;
  assign spring.springBusy   = busy;

endmodule

// File: tb/tb_spring_controller.sv
// Bench for spring_controller: a table of single-clock vectors, directed
// multi-frame sequences, then random stimulus against a frame-counting model.
module tb_spring_controller;

  localparam int MAXC = 32;
  localparam int CS   = 1;
  localparam int RS   = 8;
  localparam int SF   = 8;
  localparam int MINC = 4;
  localparam int CF   = 30;

  logic clk;
  logic resetN;
  spring_if spring();

  spring_controller #(
    .MAX_COMPRESSION(MAXC), .CHARGE_STEP(CS), .RETRACT_STEP(RS),
    .SPEED_FACTOR(SF), .MIN_COMPRESSION(MINC), .COOLDOWN_FRAMES(CF),
    .DATA_W(32)
  ) dut (
    .clk(clk),
    .resetN(resetN),
    .spring(spring)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: phase plus frame counts; outputs derived arithmetically.
  int m_phase = 0;  // 0 idle, 1 charging, 2 releasing, 3 cooling down
  int m_held  = 0;  // frames the key has been held while charging
  int m_c0    = 0;  // compression at the moment of firing
  int m_rel   = 0;  // frames since firing
  int m_cool  = 0;  // cooldown frames still to wait
  bit m_pulse = 1'b0;

  function automatic int exp_comp();
    int v;
    v = 0;
    if (m_phase == 1) begin
      v = m_held * CS;
      if (v > MAXC) v = MAXC;
    end else if (m_phase == 2) begin
      v = m_c0 - m_rel * RS;
      if (v < 0) v = 0;
    end
    return v;
  endfunction

  function automatic int exp_speed();
    return (m_phase == 2) ? -(m_c0 * SF) : 0;
  endfunction

  task automatic model_step(input bit sof, input bit key, input bit pau, input bit rl, input bit rst);
    int c;
    m_pulse = 1'b0;
    if (rst || rl) begin
      m_phase = 0; m_held = 0; m_c0 = 0; m_rel = 0; m_cool = 0;
    end else if (sof && !pau) begin
      case (m_phase)
        0: if (key) begin m_phase = 1; m_held = 1; end
        1: begin
          if (key) begin
            if (m_held * CS < MAXC) m_held++;
          end else begin
            c = exp_comp();
            if (c >= MINC) begin
              m_phase = 2; m_c0 = c; m_rel = 0; m_pulse = 1'b1;
            end else begin
              m_phase = 0;
            end
          end
        end
        2: begin
          m_rel++;
          if (m_c0 - m_rel * RS <= 0) begin m_phase = 3; m_cool = CF; end
        end
        default: begin
          m_cool--;
          if (m_cool <= 0) m_phase = 0;
        end
      endcase
    end
  endtask

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, " comp"},  {24'd0, spring.compression}, exp_comp());
    chk({tag, " speed"}, spring.springSpeedY, exp_speed());
    chk({tag, " pulse"}, {31'd0, spring.launchPulse}, {31'd0, m_pulse});
    chk({tag, " busy"},  {31'd0, spring.springBusy}, {31'd0, (m_phase != 0)});
  endtask

  // One clock: drive on the falling edge, sample 1 time unit after rising.
  task automatic cyc(input bit sof, input bit key, input bit pau = 1'b0,
                     input bit rl = 1'b0, input bit rst = 1'b0);
    @(negedge clk);
    resetN                = rst;
    spring.startOfFrame   = sof;
    spring.keyIsPressed   = key;
    spring.pause          = pau;
    spring.reset_level    = rl;
    model_step(sof, key, pau, rl, rst);
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input bit key);
    cyc(1'b1, key);
    cyc(1'b0, key);
  endtask

  typedef struct {
    bit rst; bit rl; bit pau; bit sof; bit key;
    int comp; int speed; bit pulse; bit busy;
  } vec_t;

  vec_t tbl[$];

  initial begin
    bit key_st, pau_st;
    resetN = 1'b1;
    spring.startOfFrame = 1'b0;
    spring.keyIsPressed = 1'b0;
    spring.pause        = 1'b0;
    spring.reset_level  = 1'b0;

    // rst rl pau sof key | comp speed pulse busy
    tbl.push_back('{1,0,0,1,1,  0,   0, 0, 0});
    tbl.push_back('{1,0,0,1,1,  0,   0, 0, 0});
    tbl.push_back('{1,0,0,1,1,  0,   0, 0, 0});
    tbl.push_back('{0,0,0,1,1,  1,   0, 0, 1});
    tbl.push_back('{0,0,0,0,1,  1,   0, 0, 1});
    tbl.push_back('{0,0,0,1,1,  2,   0, 0, 1});
    tbl.push_back('{0,0,0,1,1,  3,   0, 0, 1});
    tbl.push_back('{0,0,0,1,1,  4,   0, 0, 1});
    tbl.push_back('{0,0,0,0,0,  4,   0, 0, 1});
    tbl.push_back('{0,0,0,1,0,  4, -32, 1, 1});
    tbl.push_back('{0,0,0,0,0,  4, -32, 0, 1});
    tbl.push_back('{0,0,0,1,1,  0,   0, 0, 1});
    tbl.push_back('{0,0,0,1,1,  0,   0, 0, 1});
    tbl.push_back('{1,0,0,0,0,  0,   0, 0, 0});
    tbl.push_back('{0,0,0,1,1,  1,   0, 0, 1});
    tbl.push_back('{0,0,0,1,1,  2,   0, 0, 1});
    tbl.push_back('{0,0,0,1,0,  0,   0, 0, 0});
    tbl.push_back('{0,0,0,1,0,  0,   0, 0, 0});
    tbl.push_back('{0,0,0,1,1,  1,   0, 0, 1});
    tbl.push_back('{0,0,1,1,1,  1,   0, 0, 1});
    tbl.push_back('{0,1,1,1,1,  0,   0, 0, 0});

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].sof, tbl[i].key, tbl[i].pau, tbl[i].rl, tbl[i].rst);
      chk($sformatf("vec%0d comp", i),  {24'd0, spring.compression}, tbl[i].comp);
      chk($sformatf("vec%0d speed", i), spring.springSpeedY, tbl[i].speed);
      chk($sformatf("vec%0d pulse", i), {31'd0, spring.launchPulse}, {31'd0, tbl[i].pulse});
      chk($sformatf("vec%0d busy", i),  {31'd0, spring.springBusy}, {31'd0, tbl[i].busy});
    end

    // Normal launch after 20 frames, then held-key cooldown with a pause inside.
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (20) frame(1'b1);
    chk("launch charge20", {24'd0, spring.compression}, 20);
    cyc(1'b1, 1'b0);
    chk("launch pulse on", {31'd0, spring.launchPulse}, 1);
    chk("launch speed", spring.springSpeedY, -160);
    cyc(1'b0, 1'b0);
    chk("launch pulse off", {31'd0, spring.launchPulse}, 0);
    chk("launch speed hold", spring.springSpeedY, -160);
    frame(1'b1);
    chk("retract 12", {24'd0, spring.compression}, 12);
    frame(1'b1);
    chk("retract 4", {24'd0, spring.compression}, 4);
    chk("retract speed", spring.springSpeedY, -160);
    frame(1'b1);
    chk("retract 0", {24'd0, spring.compression}, 0);
    chk("cooldown speed", spring.springSpeedY, 0);
    chk("cooldown busy", {31'd0, spring.springBusy}, 1);
    repeat (10) frame(1'b1);
    repeat (5) cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b1);
    chk("cooldown paused busy", {31'd0, spring.springBusy}, 1);
    repeat (19) frame(1'b1);
    chk("cooldown 29 busy", {31'd0, spring.springBusy}, 1);
    chk("cooldown 29 comp", {24'd0, spring.compression}, 0);
    frame(1'b1);
    chk("cooldown 30 idle", {31'd0, spring.springBusy}, 0);
    chk("cooldown 30 comp", {24'd0, spring.compression}, 0);
    frame(1'b1);
    chk("recharge comp", {24'd0, spring.compression}, 1);
    chk("recharge busy", {31'd0, spring.springBusy}, 1);

    // Pause mid-charge at compression 10.
    repeat (9) frame(1'b1);
    chk("pause pre", {24'd0, spring.compression}, 10);
    repeat (5) cyc(1'b1, 1'b1, 1'b1);
    chk("pause hold", {24'd0, spring.compression}, 10);
    frame(1'b1);
    chk("pause resume", {24'd0, spring.compression}, 11);

    // Saturation at 32 and a 4-frame retract.
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (31) frame(1'b1);
    chk("sat 31", {24'd0, spring.compression}, 31);
    frame(1'b1);
    chk("sat 32", {24'd0, spring.compression}, 32);
    repeat (18) frame(1'b1);
    chk("sat 50", {24'd0, spring.compression}, 32);
    cyc(1'b1, 1'b0);
    chk("sat pulse", {31'd0, spring.launchPulse}, 1);
    chk("sat speed", spring.springSpeedY, -256);
    cyc(1'b0, 1'b0);
    repeat (3) frame(1'b0);
    chk("sat retract3 comp", {24'd0, spring.compression}, 8);
    chk("sat retract3 speed", spring.springSpeedY, -256);
    frame(1'b0);
    chk("sat retract4 comp", {24'd0, spring.compression}, 0);
    chk("sat retract4 speed", spring.springSpeedY, 0);
    chk("sat retract4 busy", {31'd0, spring.springBusy}, 1);

    // reset_level pulse while releasing.
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (10) frame(1'b1);
    cyc(1'b1, 1'b0);
    chk("rl fire speed", spring.springSpeedY, -80);
    cyc(1'b0, 1'b0);
    frame(1'b0);
    chk("rl retract comp", {24'd0, spring.compression}, 2);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("rl comp", {24'd0, spring.compression}, 0);
    chk("rl speed", spring.springSpeedY, 0);
    chk("rl busy", {31'd0, spring.springBusy}, 0);

    // Random stimulus against the model.
    key_st = 1'b0;
    pau_st = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 39) == 0) key_st = ~key_st;
      if (pau_st) begin
        if ($urandom_range(0, 5) == 0) pau_st = 1'b0;
      end else if ($urandom_range(0, 79) == 0) begin
        pau_st = 1'b1;
      end
      cyc(($urandom_range(0, 2) == 0), key_st, pau_st,
          ($urandom_range(0, 799) == 0), ($urandom_range(0, 1499) == 0));
      chk_model($sformatf("rand%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spring_controller.md
Name: spring_controller

Overview:
- Plunger/launcher controller feeding the ball stage's spring inputs. Converts key hold time into spring compression, then on release drives a launch velocity on springSpeedY for the retract window.
- Also exports the current compression so the spring renderer can draw the plunger displacement.
- State advances only on startOfFrame ticks, so timing is in frames.

Parameters:
- MAX_COMPRESSION, 32, compression saturation value in pixels (1..255)
- CHARGE_STEP, 1, compression added per frame while charging
- RETRACT_STEP, 8, compression removed per frame while releasing
- SPEED_FACTOR, 8, launch speed magnitude per pixel of compression
- MIN_COMPRESSION, 4, minimum compression required to fire
- COOLDOWN_FRAMES, 30, frames after launch during which the key is ignored

Ports:
- clk  in  1  system clock
- resetN  in  1  synchronous, active-high reset (name kept per codebase; asserted = 1)
- startOfFrame  in  1  one-clock frame tick
- keyIsPressed  in  1  launch key level, already debounced
- pause  in  1  freezes all state while high
- reset_level  in  1  synchronous level restart, same effect as reset
- springSpeedY  out  32 (int, signed)  vertical launch speed to ball stage; negative = upward
- compression  out  8  current plunger displacement in pixels
- launchPulse  out  1  one-clock strobe when firing begins
- springBusy  out  1  high in every state except IDLE

Behaviour:
- Reset: resetN = 1 at a clk edge sets state IDLE, compression 0, springSpeedY 0, launchPulse 0, cooldown counter 0, latched speed 0. reset_level has the identical effect.
- Priority: resetN, then reset_level, then pause, then the frame logic.
- Frame gating:
  - Transitions and counter updates happen only on clocks where startOfFrame = 1 and pause = 0.
  - With pause = 1, every register holds, including across frame ticks.
  - launchPulse is the only output that changes off-frame: it clears one clock after it is asserted.
- States:
  - IDLE: compression 0, springSpeedY 0. On a frame tick with keyIsPressed = 1, go to CHARGING and set compression to CHARGE_STEP on that same tick.
  - CHARGING: springSpeedY 0.
    - On each frame tick with keyIsPressed = 1: compression = min(compression + CHARGE_STEP, MAX_COMPRESSION). It holds at the maximum; there is no wrap.
    - On a frame tick with keyIsPressed = 0 and compression >= MIN_COMPRESSION: latch launchSpeed = -(compression * SPEED_FACTOR), sign-extended to 32 bits. Go to RELEASE and assert launchPulse for 1 clk.
    - On a frame tick with keyIsPressed = 0 and compression < MIN_COMPRESSION: misfire. Go to IDLE with compression 0; no pulse, no speed.
  - RELEASE: springSpeedY = launchSpeed, valid from the clock after the transition.
    - Each frame tick: compression = max(compression - RETRACT_STEP, 0). No underflow.
    - On the tick where the result is 0: go to COOLDOWN, springSpeedY becomes 0, cooldown counter = COOLDOWN_FRAMES.
    - keyIsPressed is ignored.
  - COOLDOWN: springSpeedY 0, compression 0.
    - Counter decrements once per frame tick.
    - On the tick it reaches 0, go to IDLE. A key held at that moment is not seen until the next frame tick.
    - keyIsPressed is ignored.
- Arithmetic: the product is computed in 32-bit signed. Worst case is 255 × SPEED_FACTOR, which must fit; this is a parameter-legality requirement.
- Output timing: all outputs are registered, so there is one clock of latency from the deciding frame tick.

Test Plan:
- Reset: drive resetN = 1 with the key held for 3 frames → state IDLE, compression 0, springSpeedY 0, springBusy 0. Deassert reset → CHARGING on the next frame tick with compression 1.
- Normal launch (defaults): hold key 20 frames, release → launchPulse high exactly 1 clk, springSpeedY = -160. Compression goes 20 → 12 → 4 → 0 over 3 frames. Then springSpeedY = 0 and state is COOLDOWN.
- Saturation: hold key 50 frames → compression stays at 32 from frame 32 onward. Release → springSpeedY = -256, retract takes 4 frames.
- Misfire: hold key 3 frames, release → compression 0, IDLE, no launchPulse, springSpeedY stays 0.
- Pause: pause = 1 mid-CHARGING at compression 10 for 5 frames → compression stays 10. Pause = 1 mid-COOLDOWN → counter holds. After pause is released, counting resumes with no lost or extra frames.
- Cooldown and reset_level:
  - Hold the key through COOLDOWN → no recharge for 30 frames; CHARGING begins on the first frame tick after IDLE.
  - Pulse reset_level for 1 clk during RELEASE → IDLE and springSpeedY 0 on the next clock.
